div_seq_param: RTL and testbench

Parametrised multi-cycle integer divider for the ALU/multiply-divide unit, producing quotient (lo) and remainder (hi) for signed or unsigned operands. It generalises the fixed 32-bit signed divider in three ways: operand width is set by a parameter, signed/unsigned mode is selected per operation, and it uses an explicit busy/done handshake with sticky results. It flags divide-by-zero and signed overflow, and it sits beside the multiplier, feeding the Hi/Lo registers.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_sign_fix.sv | 24 ++
 rtl/div_seq_param.sv | 147 ++++++++++++++
 tb/tb_div_seq_param.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   state_t     : FSM state encoding (IDLE, CALC, FIX, DONE)
//   div_latency : accept-to-end-of-done cycle count for a width w
//   cnt_width   : bit count of the iteration counter, $clog2(w+1)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int div_latency(input int w);
    return w + 2;
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign restoration for magnitude-based divide (and, later,
// the multiplier sign stage).
//   q_abs, r_abs : unsigned quotient / remainder magnitudes
//   neg_q, neg_r : negate quotient / remainder
//   lo, hi       : signed quotient / remainder
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] q_abs,
  input  logic [W-1:0] r_abs,
  input  logic         neg_q,
  input  logic         neg_r,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  always_comb begin
    lo = q_abs;
    hi = r_abs;
    if (neg_q) lo = -q_abs;
    if (neg_r) hi = -r_abs;
  end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised multi-cycle restoring divider (quotient on lo, remainder on
// hi), signed or unsigned per operation, with busy/done handshake and
// sticky results. All state changes on the falling clock edge.
//   clock       : datapath clock (falling edge active)
//   Reset       : synchronous, active-low
//   start       : request; sampled only in IDLE or DONE
//   signed_mode : 1 = two's complement operands, captured with start
//   dividend    : W-bit dividend, captured at accept
//   divisor     : W-bit divisor, captured at accept
//   busy        : operation in progress (CALC/FIX)
//   done        : one-cycle result pulse
//   div_zero    : last operation divided by zero
//   overflow    : last operation was most-negative / -1
//   hi, lo      : remainder, quotient
module div_seq_param
  import div_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         Reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic         overflow,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CNT_W = cnt_width(W);

  state_t state, state_nxt;

  logic [W:0]     rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   dvs;
  logic [CNT_W-1:0] cnt;
  logic           neg_q;
  logic           neg_r;
  logic           ovf_pend;

  logic           accept;
  logic [W-1:0]   dividend_abs;
  logic [W-1:0]   divisor_abs;
  logic [W+1:0]   rem_diff;
  logic [W-1:0]   hi_fix;
  logic [W-1:0]   lo_fix;

  assign accept = start && (state == IDLE || state == DONE);

  assign dividend_abs = (signed_mode && dividend[W-1]) ? -dividend : dividend;
  assign divisor_abs  = (signed_mode && divisor[W-1])  ? -divisor  : divisor;

  // Shift the next dividend bit into the remainder and trial-subtract. One
  // extra top bit beyond the W+1 remainder carries the borrow, so a set MSB
  // means the divisor did not fit and the shifted remainder is kept.
  assign rem_diff = {rem, quo[W-1]} - {2'b00, dvs};

  always_ff @(negedge clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done      = (state == DONE);
        state_nxt = IDLE;
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_W'(W - 1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clock) begin
    if (!Reset) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_pend <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      div_zero <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      if (divisor == '0) begin
        div_zero <= 1'b1;
        hi       <= dividend;
        lo       <= '1;
      end else begin
        rem      <= '0;
        quo      <= dividend_abs;
        dvs      <= divisor_abs;
        neg_q    <= signed_mode && (dividend[W-1] ^ divisor[W-1]);
        neg_r    <= signed_mode && dividend[W-1];
        // The wrapped result falls out of the normal path; only the flag
        // needs remembering until FIX.
        ovf_pend <= signed_mode && (dividend == {1'b1, {(W-1){1'b0}}})
                    && (divisor == '1);
      end
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (rem_diff[W+1]) begin
        rem <= {rem[W-1:0], quo[W-1]};
        quo <= {quo[W-2:0], 1'b0};
      end else begin
        rem <= rem_diff[W:0];
        quo <= {quo[W-2:0], 1'b1};
      end
    end else if (state == FIX) begin
      hi       <= hi_fix;
      lo       <= lo_fix;
      overflow <= ovf_pend;
    end
  end

  div_sign_fix #(.W(W)) u_sign_fix (
    .q_abs (quo),
    .r_abs (rem[W-1:0]),
    .neg_q (neg_q),
    .neg_r (neg_r),
    .lo    (lo_fix),
    .hi    (hi_fix)
  );

endmodule

// File: tb/tb_div_seq_param.sv
// Self-checking bench for div_seq_param at W=32 and W=8 (two instances on
// one clock). Expected results are queued when an operation is accepted
// and compared when the matching done pulse appears.
module tb_div_seq_param;
  import div_pkg::*;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    logic        dz;
    logic        ov;
    int          acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        start32, sm32, busy32, done32, div_zero32, overflow32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sm8, busy8, done8, div_zero8, overflow8;
  logic [7:0]  a8, b8, hi8, lo8;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   last_done32 = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t m32, m8;

  always #5 clock = ~clock;
  always @(negedge clock) cyc <= cyc + 1;

  div_seq_param #(.W(32)) u_dut32 (
    .clock(clock), .Reset(reset_n), .start(start32), .signed_mode(sm32),
    .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
    .div_zero(div_zero32), .overflow(overflow32), .hi(hi32), .lo(lo32)
  );

  div_seq_param #(.W(8)) u_dut8 (
    .clock(clock), .Reset(reset_n), .start(start8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .div_zero(div_zero8), .overflow(overflow8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] hi, input logic [63:0] lo,
                              input logic dz, input logic ov);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz; e.ov = ov; e.acc = 0;
    return e;
  endfunction

  // Reference: native 64-bit arithmetic on sign/zero-extended operands.
  function automatic exp_t model(input int w, input bit sm,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] mask, ua, ub;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    e = mk(64'd0, 64'd0, 1'b0, 1'b0);
    if (ub == 64'd0) begin
      e.dz = 1'b1; e.hi = ua; e.lo = mask;
      return e;
    end
    if (sm) begin
      sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
      sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
      if (sa == -(longint'(1) << (w - 1)) && sb == -1) e.ov = 1'b1;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
    end
    e.lo = q & mask;
    e.hi = r & mask;
    return e;
  endfunction

  // Called at a posedge; drives start, waits for the accepting negedge,
  // queues the expectation, then scrambles the operand inputs.
  task automatic issue_e(input bit w8, input bit sm, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
    int g = 0;
    while ((w8 ? busy8 : busy32) && g < 200) begin
      @(posedge clock);
      g++;
    end
    if (g >= 200) chk("accept_timeout", 64'(w8 ? busy8 : busy32), 64'd0);
    if (w8) begin start8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
    else begin start32 = 1'b1; sm32 = sm; a32 = a; b32 = b; end
    @(negedge clock);
    #1;
    e.acc = cyc;
    last_acc = cyc;
    if (w8) begin
      q8.push_back(e);
      if (e.dz) chk("dz_done8", 64'(done8), 64'd1);
      else begin
        chk("busy8", 64'(busy8), 64'd1);
        chk("dz_clr8", 64'(div_zero8), 64'd0);
        chk("ov_clr8", 64'(overflow8), 64'd0);
      end
    end else begin
      q32.push_back(e);
      if (e.dz) chk("dz_done32", 64'(done32), 64'd1);
      else begin
        chk("busy32", 64'(busy32), 64'd1);
        chk("dz_clr32", 64'(div_zero32), 64'd0);
        chk("ov_clr32", 64'(overflow32), 64'd0);
      end
    end
    @(posedge clock);
    if (w8) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom); end
    else begin start32 = 1'b0; a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom); end
  endtask

  task automatic issue(input bit w8, input bit sm, input logic [31:0] a, input logic [31:0] b);
    issue_e(w8, sm, a, b, model(w8 ? 8 : 32, sm, a, b));
  endtask

  task automatic wait_done32();
    int g = 0;
    do begin
      @(posedge clock);
      g++;
    end while (!done32 && g < 100);
    if (!done32) chk("done32_timeout", 64'(done32), 64'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((q32.size() != 0 || q8.size() != 0 || busy32 || busy8) && g < 300) begin
      @(posedge clock);
      g++;
    end
    if (g >= 300) chk("idle_timeout", 64'(q32.size() + q8.size()), 64'd0);
  endtask

  always @(posedge clock) begin
    if (done32) begin
      if (q32.size() == 0) chk("spurious_done32", 64'(done32), 64'd0);
      else begin
        m32 = q32.pop_front();
        chk("hi32", 64'(hi32), m32.hi);
        chk("lo32", 64'(lo32), m32.lo);
        chk("div_zero32", 64'(div_zero32), 64'(m32.dz));
        chk("overflow32", 64'(overflow32), 64'(m32.ov));
        chk("latency32", 64'(cyc - m32.acc), m32.dz ? 64'd0 : 64'd33);
        chk("busy_at_done32", 64'(busy32), 64'd0);
        last_done32 = cyc;
      end
    end
    if (done8) begin
      if (q8.size() == 0) chk("spurious_done8", 64'(done8), 64'd0);
      else begin
        m8 = q8.pop_front();
        chk("hi8", 64'(hi8), m8.hi);
        chk("lo8", 64'(lo8), m8.lo);
        chk("div_zero8", 64'(div_zero8), 64'(m8.dz));
        chk("overflow8", 64'(overflow8), 64'(m8.ov));
        chk("latency8", 64'(cyc - m8.acc), m8.dz ? 64'd0 : 64'd9);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start32 = 1'b0; sm32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    start8  = 1'b0; sm8  = 1'b0; a8  = 8'd0;  b8  = 8'd0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_dz32", 64'(div_zero32), 64'd0);
    chk("rst_ov32", 64'(overflow32), 64'd0);
    chk("rst_hi32", 64'(hi32), 64'd0);
    chk("rst_lo32", 64'(lo32), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_hi8", 64'(hi8), 64'd0);
    chk("rst_lo8", 64'(lo8), 64'd0);
    @(posedge clock);
    reset_n = 1'b1;

    // Directed W=32 cases with hand-computed results.
    issue_e(0, 1, 32'd100, 32'd7, mk(64'd2, 64'd14, 0, 0));
    issue_e(0, 1, 32'hFFFFFF9C, 32'd7, mk(64'hFFFFFFFE, 64'hFFFFFFF2, 0, 0));
    issue_e(0, 1, 32'd100, 32'hFFFFFFF9, mk(64'd2, 64'hFFFFFFF2, 0, 0));
    issue_e(0, 0, 32'hFFFFFFFF, 32'd2, mk(64'd1, 64'h7FFFFFFF, 0, 0));
    issue_e(0, 1, 32'hFFFFFFFF, 32'd2, mk(64'hFFFFFFFF, 64'd0, 0, 0));
    issue_e(0, 1, 32'h1234, 32'd0, mk(64'h1234, 64'hFFFFFFFF, 1, 0));
    issue_e(0, 0, 32'd1000, 32'd10, mk(64'd0, 64'd100, 0, 0));
    issue_e(0, 1, 32'h80000000, 32'hFFFFFFFF, mk(64'd0, 64'h80000000, 0, 1));
    wait_idle();

    // Directed W=8 cases.
    issue_e(1, 1, 32'h80, 32'h03, mk(64'hFE, 64'hD6, 0, 0));
    issue_e(1, 1, 32'h80, 32'hFF, mk(64'h00, 64'h80, 0, 1));
    issue_e(1, 1, 32'h5A, 32'h00, mk(64'h5A, 64'hFF, 1, 0));
    issue_e(1, 0, 32'd200, 32'd7, mk(64'd4, 64'd28, 0, 0));
    issue_e(1, 1, 32'h7F, 32'hF9, mk(64'h01, 64'hEE, 0, 0));
    wait_idle();

    // Random operands, checked against the native-arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 30);
      issue(1'(i % 2), 1'($urandom), a, b);
    end
    wait_idle();

    // start while busy must be ignored.
    issue(0, 1, 32'd12345, 32'd67);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      start32 = 1'b1; a32 = 32'hDEAD; b32 = 32'd0; sm32 = 1'b0;
      @(negedge clock);
      #1;
      chk("ignore_busy32", 64'(busy32), 64'd1);
    end
    @(posedge clock);
    start32 = 1'b0;
    wait_idle();

    // Back-to-back: start presented during done is accepted immediately.
    issue(0, 0, 32'd77777, 32'd123);
    wait_done32();
    issue(0, 1, 32'hFFFF0000, 32'd9);
    chk("b2b_gap32", 64'(last_acc - last_done32), 64'd1);
    wait_idle();

    // Reset mid-operation, with a simultaneous divide-by-zero start that
    // reset must override.
    issue(0, 1, 32'd99999, 32'd13);
    repeat (9) @(posedge clock);
    reset_n = 1'b0;
    start32 = 1'b1; b32 = 32'd0;
    start8  = 1'b1; b8  = 8'd0;
    @(negedge clock);
    #1;
    q32.delete();
    chk("abort_busy32", 64'(busy32), 64'd0);
    chk("abort_done32", 64'(done32), 64'd0);
    chk("abort_hi32", 64'(hi32), 64'd0);
    chk("abort_lo32", 64'(lo32), 64'd0);
    chk("abort_dz32", 64'(div_zero32), 64'd0);
    chk("abort_ov32", 64'(overflow32), 64'd0);
    chk("abort_done8", 64'(done8), 64'd0);
    chk("abort_hi8", 64'(hi8), 64'd0);
    chk("abort_lo8", 64'(lo8), 64'd0);
    @(posedge clock);
    reset_n = 1'b1;
    start32 = 1'b0;
    start8  = 1'b0;
    repeat (40) @(posedge clock);
    chk("post_abort_busy32", 64'(busy32), 64'd0);
    chk("post_abort_lo32", 64'(lo32), 64'd0);

    // Normal operation resumes after reset.
    issue_e(0, 1, 32'd100, 32'd7, mk(64'd2, 64'd14, 0, 0));
    issue_e(1, 1, 32'h80, 32'h03, mk(64'hFE, 64'hD6, 0, 0));
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
